axis_byte_packetizer: RTL and testbench
=======================================

# axis_byte_packetizer

Host-side AXI-Stream transmitter that feeds the processor's slave stream. Accepts a byte stream with an end-of-packet flag, for example from a UART receiver or a test source. Packs the bytes little-endian into `TDATA_WIDTH_BYTES`-wide beats. Drives `m_tkeep` on the final partial beat and `m_tlast` on the last beat of every packet.

## Interface
- `TDATA_WIDTH_BYTES`, default 4: output beat width in bytes (N); legal range 1..64.
- `TIMEOUT_CYCLES`, default 1024: idle-flush threshold; used only when the timeout feature is compiled in; legal range ≥1.
- `clk`, input, 1: single clock; all logic on the rising edge.
- `arstn`, input, 1: reset, asynchronous, active-low.
- `in_valid`, input, 1: input byte valid.
- `in_ready`, output, 1: input byte accepted when `in_valid && in_ready`.
- `in_data`, input, 8: payload byte.
- `in_last`, input, 1: this byte ends the packet.
- `m_tvalid`, output, 1: AXIS master valid.
- `m_tready`, input, 1: AXIS master ready.
- `m_tdata`, output, N*8: beat data; byte k of the beat is on bits [8k+7:8k].
- `m_tkeep`, output, N: contiguous low-aligned byte enables.
- `m_tlast`, output, 1: final beat of the packet.

## Operation
- Accumulator: holds up to N-1 pending bytes plus a byte count `cnt` (0..N-1).
  - The first byte of a beat goes to lane 0.
- Output register: one beat deep; drives `m_tdata`, `m_tkeep`, `m_tlast` and `m_tvalid`.
- Accepted byte that does not complete a beat (`cnt < N-1` and `!in_last`):
  - Stored in lane `cnt`; `cnt` increments.
- Completing byte (`cnt == N-1`, or `in_last`):
  - Accumulator contents plus this byte move to the output register.
  - `m_tkeep` = `(1<<(cnt+1))-1`; `m_tlast` = `in_last`; `cnt` returns to 0.
  - Unused lanes are driven as 0.
- `in_ready` = `arstn && (!m_tvalid || m_tready) && !flush`, combinational.
  - Input stalls only while a beat is held un-accepted or a flush occurs.
- Output handshake:
  - `m_tvalid` deasserts after acceptance unless a new beat loads in the same cycle.
  - While `m_tvalid && !m_tready`, `m_tdata`, `m_tkeep` and `m_tlast` are held stable.
- Zero-length packets cannot occur: every `in_last` carries a byte.
- A packet ending exactly on a beat boundary yields `m_tkeep` all-ones with `m_tlast=1`; no extra empty beat follows.

## Timing
- Latency: completing byte accepted in cycle k, so `m_tvalid=1` at cycle k+1.
- Throughput: 1 byte per cycle sustained while `m_tready=1`.
- Reset values:
  - `m_tvalid=0`, `m_tdata=0`, `m_tkeep=0`, `m_tlast=0`; `cnt=0`; accumulator cleared.
  - `in_ready=0` while `arstn=0`.
- Reset mid-packet: the partial accumulator and any pending beat are discarded; no beat is emitted for them.
- Simultaneous output acceptance and completing byte in one cycle: the new beat loads and `m_tvalid` stays 1.

## Configuration
- Macro: `AXIS_BYTE_PACKETIZER_TIMEOUT_EN`.
- Defined, idle counter behaviour:
  - Counts cycles in which `cnt>0` and no byte is accepted.
  - Clears on any accepted byte or when `cnt==0`.
- Defined, flush behaviour:
  - On reaching `TIMEOUT_CYCLES`, `flush` asserts and is registered from the counter.
  - The flush occurs once the output slot is free.
  - The partial accumulator moves out as a beat with `m_tkeep` for `cnt` bytes and `m_tlast=1`; `cnt` returns to 0.
  - `in_ready` is 0 in the flush cycle.
  - If a byte is accepted in the cycle the count would expire, the byte wins and the counter clears.
- Undefined:
  - No counter logic is built and `flush` is tied to 0.
  - Partial bytes are held indefinitely until more input arrives.

## Structure
- Shared package `axis_byte_packetizer_pkg`:
  - `BYTE_W=8` constant.
  - Function `keep_mask(count)` returning the low-aligned N-bit mask.
  - Width-derived `CNT_W=$clog2(N)` helper.
- Single module; no sub-module. Accumulator, output register and timeout counter are small enough to live in one module.

## Test plan
All scenarios use N=4 and TIMEOUT_CYCLES=8.
- Bytes 0x11,0x22,0x33,0x44 (`in_last` on 0x44), `m_tready=1` → one beat `0x44332211`, keep `0xF`, last 1, valid the cycle after 0x44 is accepted.
- Bytes 0xA0..0xA5 (`in_last` on 0xA5) → beat `0xA3A2A1A0`, keep `0xF`, last 0, then beat `0x0000A5A4`, keep `0x3`, last 1.
- Single byte 0x7E with `in_last` → beat `0x0000007E`, keep `0x1`, last 1.
- Backpressure: hold `m_tready=0` with a beat pending and feed 8 bytes → `in_ready` drops, `m_tdata` stable; after release all 8 bytes appear in order as two full beats.
- Timeout: bytes 0x01,0x02 without `in_last`, then idle.
  - Macro on → beat `0x00000201`, keep `0x3`, last 1, after 8 idle cycles.
  - Macro off → no beat within 100 cycles.
- Reset: after 3 bytes, pulse `arstn` low → `m_tvalid=0` immediately; then 0x01..0x04 with last → clean beat `0x04030201`, keep `0xF`.

Source files
------------

// File: rtl/axis_byte_packetizer_pkg.sv
// Shared definitions for axis_byte_packetizer: byte width, tkeep mask helper
// and the byte-count width helper.
package axis_byte_packetizer_pkg;

  localparam int BYTE_W    = 8;
  localparam int MAX_BYTES = 64;

  // Byte-count width for an N-byte beat; a 1-byte beat still needs one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Low-aligned byte-enable mask with 'count' ones; callers truncate to N.
  function automatic logic [MAX_BYTES-1:0] keep_mask(input int count);
    if (count <= 0) return '0;
    if (count >= MAX_BYTES) return '1;
    return (64'(1) << count) - 64'(1);
  endfunction

endpackage

// File: rtl/axis_byte_packetizer.sv
// Packs a byte stream little-endian into N-byte AXI-Stream beats with tkeep/tlast.
// Optional idle-flush of partial beats: define AXIS_BYTE_PACKETIZER_TIMEOUT_EN.
module axis_byte_packetizer
  import axis_byte_packetizer_pkg::*;
#(
  parameter int TDATA_WIDTH_BYTES = 4,
  parameter int TIMEOUT_CYCLES    = 1024
) (
  input  logic                                clk,
  input  logic                                arstn,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [BYTE_W-1:0]                   in_data,
  input  logic                                in_last,
  output logic                                m_tvalid,
  input  logic                                m_tready,
  output logic [TDATA_WIDTH_BYTES*BYTE_W-1:0] m_tdata,
  output logic [TDATA_WIDTH_BYTES-1:0]        m_tkeep,
  output logic                                m_tlast
);

  localparam int N  = TDATA_WIDTH_BYTES;
  localparam int CW = cnt_w(N);

  logic [N-1:0][BYTE_W-1:0] acc;
  logic [N-1:0][BYTE_W-1:0] beat;
  logic [CW-1:0]            cnt;
  logic                     flush;
  logic                     slot_free;
  logic                     accept;
  logic                     complete;

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid never waits on ready, and a raised m_tvalid holds its
  // beat (data/keep/last) unchanged until m_tready takes it.
  assign slot_free = !m_tvalid || m_tready;
  assign in_ready  = arstn && slot_free && !flush;
  assign accept    = in_valid && in_ready;
  assign complete  = accept && (in_last || (cnt == CW'(N - 1)));

  // Lanes above cnt are already zero because the accumulator clears per beat.
  always_comb begin
    beat      = acc;
    beat[cnt] = in_data;
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      acc      <= '0;
      cnt      <= '0;
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tkeep  <= '0;
      m_tlast  <= 1'b0;
    end else if (complete) begin
      m_tdata  <= beat;
      m_tkeep  <= N'(keep_mask(int'(cnt) + 1));
      m_tlast  <= in_last;
      m_tvalid <= 1'b1;
      acc      <= '0;
      cnt      <= '0;
    end else if (flush && slot_free) begin
      m_tdata  <= acc;
      m_tkeep  <= N'(keep_mask(int'(cnt)));
      m_tlast  <= 1'b1;
      m_tvalid <= 1'b1;
      acc      <= '0;
      cnt      <= '0;
    end else begin
      if (m_tready) m_tvalid <= 1'b0;
      if (accept) begin
        acc[cnt] <= in_data;
        cnt      <= cnt + CW'(1);
      end
    end
  end

`ifdef AXIS_BYTE_PACKETIZER_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] idle_cnt;

  // flush stays high until the output slot frees and the partial beat leaves.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      idle_cnt <= '0;
      flush    <= 1'b0;
    end else if (flush) begin
      idle_cnt <= '0;
      if (slot_free) flush <= 1'b0;
    end else if (accept || cnt == '0) begin
      idle_cnt <= '0;
    end else if (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
      idle_cnt <= '0;
      flush    <= 1'b1;
    end else begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end
`else
  // Without the timeout build the threshold is meaningless; flush is constant 0.
  assign flush = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_axis_byte_packetizer.sv
// Directed self-checking bench for axis_byte_packetizer (N=4, timeout 8).
`timescale 1ns/1ps
module tb_axis_byte_packetizer;

  localparam int N  = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          arstn = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [7:0]    in_data = 8'h00;
  logic          in_last = 1'b0;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [N*8-1:0] m_tdata;
  logic [N-1:0]  m_tkeep;
  logic          m_tlast;

  logic [36:0] exp_q[$];
  logic [36:0] mon_e;
  int n_cmp = 0;
  int n_err = 0;

  axis_byte_packetizer #(.TDATA_WIDTH_BYTES(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .arstn(arstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
    .m_tkeep(m_tkeep), .m_tlast(m_tlast)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    exp_q.push_back({l, k, d});
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l, output int waited);
    logic hs;
    hs = 1'b0;
    waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!hs && waited < 200) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
      if (!hs) waited++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("byte_accepted", 64'(hs), 64'(1));
  endtask

  // scoreboard: compare every accepted beat against the expected queue
  always @(negedge clk) begin
    if (arstn && m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        check("beat_expected", 64'(exp_q.size()), 64'(1));
      end else begin
        mon_e = exp_q.pop_front();
        check("beat_data", 64'(m_tdata), 64'(mon_e[31:0]));
        check("beat_keep", 64'(m_tkeep), 64'(mon_e[35:32]));
        check("beat_last", 64'(m_tlast), 64'(mon_e[36]));
      end
    end
  end

  initial begin
    int w;
    int c;

    // reset state
    tick(2);
    check("rst_tvalid", 64'(m_tvalid), 64'(0));
    check("rst_tdata",  64'(m_tdata),  64'(0));
    check("rst_tkeep",  64'(m_tkeep),  64'(0));
    check("rst_tlast",  64'(m_tlast),  64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(0));
    arstn = 1'b1;
    m_tready = 1'b1;
    tick(1);
    check("in_ready_idle", 64'(in_ready), 64'(1));

    // full packet in one beat, latency check
    expect_beat(32'h44332211, 4'hF, 1'b1);
    send_byte(8'h11, 1'b0, w);
    send_byte(8'h22, 1'b0, w);
    send_byte(8'h33, 1'b0, w);
    check("t1_no_early_valid", 64'(m_tvalid), 64'(0));
    send_byte(8'h44, 1'b1, w);
    check("t1_latency", 64'(m_tvalid), 64'(1));
    tick(2);

    // six bytes: full beat then partial beat, back to back
    expect_beat(32'hA3A2A1A0, 4'hF, 1'b0);
    expect_beat(32'h0000A5A4, 4'h3, 1'b1);
    for (int i = 0; i < 6; i++) begin
      send_byte(8'(8'hA0 + i), (i == 5), w);
      check("t2_tput", 64'(w), 64'(0));
    end
    tick(2);

    // single-byte packets, including back-to-back load while beat is taken
    expect_beat(32'h0000007E, 4'h1, 1'b1);
    send_byte(8'h7E, 1'b1, w);
    tick(2);
    expect_beat(32'h00000051, 4'h1, 1'b1);
    expect_beat(32'h00000052, 4'h1, 1'b1);
    expect_beat(32'h00000053, 4'h1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'(8'h51 + i), 1'b1, w);
      check("t3_tput", 64'(w), 64'(0));
    end
    tick(2);

    // backpressure
    m_tready = 1'b0;
    expect_beat(32'hB3B2B1B0, 4'hF, 1'b0);
    expect_beat(32'hB7B6B5B4, 4'hF, 1'b1);
    fork
      begin
        int wd;
        for (int i = 0; i < 8; i++) send_byte(8'(8'hB0 + i), (i == 7), wd);
      end
      begin
        tick(12);
        check("bp_in_ready", 64'(in_ready), 64'(0));
        check("bp_tvalid",   64'(m_tvalid), 64'(1));
        check("bp_tdata",    64'(m_tdata),  64'(32'hB3B2B1B0));
        tick(3);
        check("bp_stable",   64'(m_tdata),  64'(32'hB3B2B1B0));
        check("bp_keep",     64'(m_tkeep),  64'(4'hF));
        m_tready = 1'b1;
      end
    join
    tick(3);

    // idle timeout
    send_byte(8'h01, 1'b0, w);
    send_byte(8'h02, 1'b0, w);
`ifdef AXIS_BYTE_PACKETIZER_TIMEOUT_EN
    expect_beat(32'h00000201, 4'h3, 1'b1);
    tick(7);
    check("to_early", 64'(m_tvalid), 64'(0));
    c = 0;
    while (!m_tvalid && c < 20) begin
      tick(1);
      c++;
    end
    check("to_flush", 64'(m_tvalid), 64'(1));
    tick(2);
`else
    expect_beat(32'h00030201, 4'h7, 1'b1);
    tick(100);
    check("no_flush", 64'(m_tvalid), 64'(0));
    send_byte(8'h03, 1'b1, w);
    tick(2);
`endif

    // reset with a pending beat, then with a partial accumulator
    m_tready = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(8'(8'hC0 + i), 1'b0, w);
    check("rst_pending", 64'(m_tvalid), 64'(1));
    arstn = 1'b0;
    #1;
    check("rst_async_tvalid", 64'(m_tvalid), 64'(0));
    check("rst_async_keep",   64'(m_tkeep),  64'(0));
    check("rst_async_ready",  64'(in_ready), 64'(0));
    tick(1);
    arstn = 1'b1;
    m_tready = 1'b1;
    tick(1);
    for (int i = 0; i < 3; i++) send_byte(8'(8'hD0 + i), 1'b0, w);
    arstn = 1'b0;
    #1;
    check("rst2_tvalid", 64'(m_tvalid), 64'(0));
    tick(1);
    arstn = 1'b1;
    tick(1);
    expect_beat(32'h04030201, 4'hF, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'(8'h01 + i), (i == 3), w);
    tick(3);

    // final report
    c = 0;
    while (exp_q.size() > 0 && c < 50) begin
      tick(1);
      c++;
    end
    check("drain", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
